// File: rtl/lsu_axi_master.sv
// Load/store bus master: one LSU request at a time becomes one AXI-lite read or write.
// Optional LSU_MISALIGN_CHECK_EN: misaligned h/hu/w requests skip the bus and return an error.
module lsu_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_op,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_wen,
  output logic [2:0]        mem_readop,
  output logic              mem_awvalid,
  input  logic              mem_awready,
  output logic [ADDR_W-1:0] mem_awaddr,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_bvalid,
  output logic              mem_bready,
  input  logic [1:0]        mem_bresp,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [1:0]        mem_rresp,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RESP} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [2:0]        op_q, op_n;
  logic              read_q, read_n;
  logic              wen_q, wen_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [3:0]        wstrb_q, wstrb_n;
  logic              aw_done, aw_done_n;
  logic              w_done, w_done_n;
  logic [DATA_W-1:0] rdata_q, rdata_n;
  logic              err_q, err_n;

  logic [1:0]        off;
  logic [3:0]        strb_base;
  logic [3:0]        strb_al;
  logic [DATA_W-1:0] wdata_al;
  logic              misaligned;
  logic              aw_hs, w_hs;

  // Lanes shifted past byte 3 fall off the top of the word.
  assign off      = req_addr[1:0];
  assign wdata_al = req_wdata << {off, 3'b000};
  assign strb_al  = strb_base << off;

  always_comb begin
    case (req_op[1:0])
      2'd0:    strb_base = 4'b0001;
      2'd1:    strb_base = 4'b0011;
      2'd2:    strb_base = 4'b1111;
      default: strb_base = 4'b0000;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = ((req_op[1:0] == 2'd1) && req_addr[0]) ||
                      ((req_op[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Valids are pure functions of registered state, never of the ready inputs.
  assign req_ready   = (state == IDLE);
  assign mem_arvalid = (state == RD_ADDR);
  assign mem_rready  = (state == RD_DATA);
  assign mem_awvalid = (state == WR) && !aw_done;
  assign mem_wvalid  = (state == WR) && !w_done;
  assign mem_bready  = (state == WR_RESP);
  assign resp_valid  = (state == RESP);

  assign aw_hs = mem_awvalid && mem_awready;
  assign w_hs  = mem_wvalid && mem_wready;

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_read   = read_q;
  assign mem_wen    = wen_q;
  assign mem_readop = op_q;
  assign mem_awaddr = addr_q;
  assign mem_araddr = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = {4'b0000, wstrb_q};

  always_comb begin
    // NOTE: every signal gets a hold-value default up front so no path leaves it unassigned (no latches).
    state_n   = state;
    addr_n    = addr_q;
    op_n      = op_q;
    read_n    = read_q;
    wen_n     = wen_q;
    wdata_n   = wdata_q;
    wstrb_n   = wstrb_q;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    rdata_n   = rdata_q;
    err_n     = err_q;

    case (state)
      IDLE: begin
        if (req_valid) begin
          addr_n    = req_addr;
          op_n      = req_op;
          wdata_n   = wdata_al;
          wstrb_n   = strb_al;
          rdata_n   = '0;
          err_n     = 1'b0;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          read_n    = !req_wen && !misaligned;
          wen_n     = req_wen && !misaligned;
          if (misaligned) begin
            err_n   = 1'b1;
            state_n = RESP;
          end else if (req_wen) begin
            state_n = WR;
          end else begin
            state_n = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (mem_arready) state_n = RD_DATA;
      end
      RD_DATA: begin
        if (mem_rvalid) begin
          rdata_n = mem_rdata;
          err_n   = |mem_rresp;
          state_n = RESP;
        end
      end
      WR: begin
        // AW and W complete independently; the flags remember which is already done.
        aw_done_n = aw_done || aw_hs;
        w_done_n  = w_done || w_hs;
        if (aw_done_n && w_done_n) begin
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          state_n   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (mem_bvalid) begin
          err_n   = |mem_bresp;
          state_n = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          read_n  = 1'b0;
          wen_n   = 1'b0;
          op_n    = 3'd0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      op_q    <= '0;
      read_q  <= 1'b0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values computed above.
      state   <= state_n;
      addr_q  <= addr_n;
      op_q    <= op_n;
      read_q  <= read_n;
      wen_q   <= wen_n;
      wdata_q <= wdata_n;
      wstrb_q <= wstrb_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
      rdata_q <= rdata_n;
      err_q   <= err_n;
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: a cycle-level AXI-lite slave with programmable stalls and an
// arithmetic reference model of alignment, latency and error rules.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_op;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_wen;
  logic [2:0]  mem_readop;
  logic        mem_awvalid, mem_awready, mem_wvalid, mem_wready;
  logic [31:0] mem_awaddr, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_bvalid, mem_bready;
  logic [1:0]  mem_bresp;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
  logic [31:0] mem_araddr, mem_rdata;
  logic [1:0]  mem_rresp;

  int vectors = 0;
  int miscompares = 0;

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit MIS_CHK = 1'b1;
`else
  localparam bit MIS_CHK = 1'b0;
`endif

  always #5 clk = ~clk;

  lsu_axi_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_wen(mem_wen), .mem_readop(mem_readop),
    .mem_awvalid(mem_awvalid), .mem_awready(mem_awready), .mem_awaddr(mem_awaddr),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_bvalid(mem_bvalid), .mem_bready(mem_bready), .mem_bresp(mem_bresp),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .mem_rresp(mem_rresp), .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          lat;
    int          ar_cycles, aw_cycles, w_cycles;
    int          ar_hs, r_hs, aw_hs, w_hs, b_hs;
    int          resp_cycles;
    int          viol;
    int          unstable;
    bit          timeout;
    bit          after_ok;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] wdata;
    logic [7:0]  wstrb;
    logic [31:0] araddr, awaddr;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic int size_bytes(logic [2:0] op);
    int k;
    k = int'(op) % 4;
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  function automatic bit model_mis(logic [31:0] a, logic [2:0] op);
    return MIS_CHK && (size_bytes(op) > 1) && ((int'(a[1:0]) % size_bytes(op)) != 0);
  endfunction

  function automatic logic [31:0] model_wdata(logic [31:0] d, logic [31:0] a);
    logic [63:0] v;
    v = {32'd0, d} * (64'd1 << (8 * int'(a[1:0])));
    return v[31:0];
  endfunction

  function automatic logic [7:0] model_wstrb(logic [31:0] a, logic [2:0] op);
    int m;
    m = ((1 << size_bytes(op)) - 1) << int'(a[1:0]);
    return {4'b0000, 4'(m)};
  endfunction

  function automatic int model_lat(bit wen, bit mis, int ar_lat, int aw_lat, int w_lat,
                                   int b_lat, int r_lat);
    if (mis) return 1;
    if (!wen) return 3 + ar_lat + r_lat;
    return 3 + ((aw_lat > w_lat) ? aw_lat : w_lat) + b_lat;
  endfunction

  // ---------------- slave + observer ----------------
  // Called just after a negedge with the DUT idle; returns just after the negedge that
  // follows the response handshake.
  task automatic run_txn(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] op, input int ar_lat, input int aw_lat,
                         input int w_lat, input int b_lat, input int r_lat, input int rr_lat,
                         input logic [1:0] code, input logic [31:0] sdata, output obs_t o);
    int  c, ar_cnt, aw_cnt, w_cnt, rr_cnt, r_wait, b_wait;
    bit  done, b_sched, ar_pend, aw_pend, w_pend;
    o = '{default: 0};
    o.lat = -1;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; rr_cnt = 0; r_wait = -1; b_wait = -1;
    done = 0; b_sched = 0; ar_pend = 0; aw_pend = 0; w_pend = 0;
    if (req_ready !== 1'b1) o.viol++;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_op = op;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_wen = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_op = 3'($urandom);
    c = 1;
    while (!done && c < 200) begin
      if (req_ready !== 1'b0) o.viol++;
      if (r_wait > 0) r_wait--;
      mem_rvalid = (r_wait == 0);
      mem_rdata  = mem_rvalid ? sdata : $urandom;
      mem_rresp  = mem_rvalid ? code : 2'($urandom);
      if (mem_rvalid && mem_rready) begin o.r_hs++; r_wait = -1; end
      if (b_wait > 0) b_wait--;
      mem_bvalid = (b_wait == 0);
      mem_bresp  = mem_bvalid ? code : 2'($urandom);
      if (mem_bvalid && mem_bready) begin o.b_hs++; b_wait = -1; end
      if (mem_arvalid) begin
        o.ar_cycles++; o.araddr = mem_araddr;
        if (wen || mem_read !== 1'b1 || mem_wen !== 1'b0 || mem_readop !== op) o.viol++;
        mem_arready = (ar_cnt >= ar_lat); ar_cnt++;
        if (mem_arready) begin o.ar_hs++; r_wait = r_lat + 1; end
      end else begin
        if (ar_pend) o.viol++;
        mem_arready = 1'($urandom);
      end
      ar_pend = mem_arvalid && !mem_arready;
      if (mem_awvalid) begin
        o.aw_cycles++; o.awaddr = mem_awaddr;
        if (!wen || mem_wen !== 1'b1 || mem_read !== 1'b0 || mem_readop !== op) o.viol++;
        mem_awready = (aw_cnt >= aw_lat); aw_cnt++;
        if (mem_awready) o.aw_hs++;
      end else begin
        if (aw_pend) o.viol++;
        mem_awready = 1'($urandom);
      end
      aw_pend = mem_awvalid && !mem_awready;
      if (mem_wvalid) begin
        o.w_cycles++; o.wdata = mem_wdata; o.wstrb = mem_wstrb;
        if (!wen) o.viol++;
        mem_wready = (w_cnt >= w_lat); w_cnt++;
        if (mem_wready) o.w_hs++;
      end else begin
        if (w_pend) o.viol++;
        mem_wready = 1'($urandom);
      end
      w_pend = mem_wvalid && !mem_wready;
      if (!b_sched && o.aw_hs > 0 && o.w_hs > 0) begin b_wait = b_lat + 1; b_sched = 1; end
      if (resp_valid) begin
        o.resp_cycles++;
        if (o.lat < 0) begin
          o.lat = c; o.rdata = resp_rdata; o.err = resp_err;
        end else if (resp_rdata !== o.rdata || resp_err !== o.err) begin
          o.unstable++;
        end
        resp_ready = (rr_cnt >= rr_lat); rr_cnt++;
        if (resp_ready) done = 1;
      end else begin
        if (o.lat >= 0) o.unstable++;
        resp_ready = 1'($urandom);
      end
      @(negedge clk);
      c++;
    end
    o.timeout = !done;
    resp_ready = 0; mem_arready = 0; mem_awready = 0; mem_wready = 0;
    mem_rvalid = 0; mem_bvalid = 0;
    o.after_ok = (resp_valid === 1'b0) && (req_ready === 1'b1) && (mem_arvalid === 1'b0) &&
                 (mem_awvalid === 1'b0) && (mem_wvalid === 1'b0) && (mem_rready === 1'b0) &&
                 (mem_bready === 1'b0) && (mem_read === 1'b0) && (mem_wen === 1'b0) &&
                 (mem_readop === 3'd0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] idle_bits;
    rst = 1'b0;
    req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_op = 0; resp_ready = 0;
    mem_awready = 0; mem_wready = 0; mem_bvalid = 0; mem_bresp = 0;
    mem_arready = 0; mem_rvalid = 0; mem_rresp = 0; mem_rdata = 0;
    #1;
    idle_bits = {mem_arvalid, mem_awvalid, mem_wvalid, mem_rready, mem_bready, resp_valid,
                 resp_err, mem_read, mem_wen, mem_readop, mem_wstrb, 13'd0};
    vectors++;
    if (idle_bits !== 32'd0) begin
      miscompares++; $display("FAIL reset_ctrl: got %h want 00000000", idle_bits);
    end
    vectors++;
    if ((mem_wdata | mem_araddr | mem_awaddr | resp_rdata) !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_data: got wdata=%h araddr=%h awaddr=%h rdata=%h want all 0",
               mem_wdata, mem_araddr, mem_awaddr, resp_rdata);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_store_byte();
    obs_t o;
    run_txn(1, 32'h8000_0003, 32'h0000_00A5, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, o);
    vectors++;
    if (o.wdata !== 32'hA500_0000) begin
      miscompares++; $display("FAIL sb_wdata: got %h want a5000000", o.wdata);
    end
    vectors++;
    if (o.wstrb !== 8'h08) begin
      miscompares++; $display("FAIL sb_wstrb: got %h want 08", o.wstrb);
    end
    vectors++;
    if (o.lat !== 3 || o.err !== 1'b0 || o.rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL sb_resp: got lat=%0d err=%b rdata=%h want lat=3 err=0 rdata=0",
               o.lat, o.err, o.rdata);
    end
    vectors++;
    if (o.awaddr !== 32'h8000_0003 || o.b_hs !== 1 || o.viol !== 0 || !o.after_ok) begin
      miscompares++;
      $display("FAIL sb_bus: got awaddr=%h b_hs=%0d viol=%0d after_ok=%b", o.awaddr,
               o.b_hs, o.viol, o.after_ok);
    end
  endtask

  task automatic test_load_stall();
    obs_t o;
    run_txn(0, 32'h8000_0000, 32'h0, 3'd2, 3, 0, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, o);
    vectors++;
    if (o.ar_cycles !== 4 || o.ar_hs !== 1) begin
      miscompares++;
      $display("FAIL lw_stall_ar: got cycles=%0d hs=%0d want 4/1", o.ar_cycles, o.ar_hs);
    end
    vectors++;
    if (o.rdata !== 32'hDEAD_BEEF || o.err !== 1'b0 || o.lat !== 6) begin
      miscompares++;
      $display("FAIL lw_stall_resp: got rdata=%h err=%b lat=%0d want deadbeef/0/6",
               o.rdata, o.err, o.lat);
    end
    vectors++;
    if (o.viol !== 0 || !o.after_ok) begin
      miscompares++;
      $display("FAIL lw_stall_sideband: got viol=%0d after_ok=%b want 0/1", o.viol, o.after_ok);
    end
  endtask

  task automatic test_store_w_first();
    obs_t o;
    run_txn(1, 32'h8000_0010, 32'h1234_5678, 3'd2, 0, 2, 0, 0, 0, 0, 2'b00, 32'h0, o);
    vectors++;
    if (o.aw_cycles !== 3 || o.w_cycles !== 1) begin
      miscompares++;
      $display("FAIL sw_split_valids: got aw=%0d w=%0d cycles want 3/1", o.aw_cycles, o.w_cycles);
    end
    vectors++;
    if (o.b_hs !== 1 || o.resp_cycles !== 1 || o.lat !== 5) begin
      miscompares++;
      $display("FAIL sw_split_resp: got b_hs=%0d resp=%0d lat=%0d want 1/1/5",
               o.b_hs, o.resp_cycles, o.lat);
    end
    vectors++;
    if (o.wdata !== 32'h1234_5678 || o.wstrb !== 8'h0F || o.viol !== 0) begin
      miscompares++;
      $display("FAIL sw_split_data: got wdata=%h wstrb=%h viol=%0d", o.wdata, o.wstrb, o.viol);
    end
  endtask

  task automatic test_load_err_backpressure();
    obs_t o;
    run_txn(0, 32'h8000_0024, 32'h0, 3'd2, 0, 0, 0, 0, 1, 4, 2'b10, 32'hCAFE_F00D, o);
    vectors++;
    if (o.err !== 1'b1 || o.rdata !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL lw_err_value: got err=%b rdata=%h want 1/cafef00d", o.err, o.rdata);
    end
    vectors++;
    if (o.resp_cycles !== 5 || o.unstable !== 0 || o.lat !== 4) begin
      miscompares++;
      $display("FAIL lw_err_hold: got resp=%0d unstable=%0d lat=%0d want 5/0/4",
               o.resp_cycles, o.unstable, o.lat);
    end
  endtask

  task automatic test_misalign();
    obs_t o;
    logic [31:0] exp_araddr, exp_rdata;
    exp_araddr = MIS_CHK ? 32'h0 : 32'h8000_0001;
    exp_rdata  = MIS_CHK ? 32'h0 : 32'h0000_BEEF;
    run_txn(0, 32'h8000_0001, 32'h0, 3'd1, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0000_BEEF, o);
    vectors++;
    if (o.ar_cycles !== (MIS_CHK ? 0 : 1) || o.araddr !== exp_araddr) begin
      miscompares++;
      $display("FAIL lh_mis_bus: got ar_cycles=%0d araddr=%h want %0d/%h", o.ar_cycles,
               o.araddr, MIS_CHK ? 0 : 1, exp_araddr);
    end
    vectors++;
    if (o.err !== MIS_CHK || o.lat !== (MIS_CHK ? 1 : 3) || o.rdata !== exp_rdata) begin
      miscompares++;
      $display("FAIL lh_mis_resp: got err=%b lat=%0d rdata=%h want %b/%0d/%h", o.err, o.lat,
               o.rdata, MIS_CHK, MIS_CHK ? 1 : 3, exp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic [7:0] bits;
    req_valid = 1; req_wen = 1; req_addr = 32'h8000_0040; req_wdata = 32'h5555_AAAA;
    req_op = 3'd2;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; mem_awready = 1; mem_wready = 1;
    @(posedge clk);
    @(negedge clk);
    mem_awready = 0; mem_wready = 0;
    vectors++;
    if (mem_bready !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_in_wr_resp: got bready=%b want 1", mem_bready);
    end
    #2 rst = 1'b0;
    #1;
    bits = {mem_arvalid, mem_awvalid, mem_wvalid, mem_rready, mem_bready, resp_valid,
            mem_wen, mem_read};
    vectors++;
    if (bits !== 8'd0) begin
      miscompares++; $display("FAIL rstmid_async: got %b want 00000000", bits);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || resp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_release: got req_ready=%b resp_err=%b want 1/0", req_ready, resp_err);
    end
    run_txn(0, 32'h8000_0008, 32'h0, 3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0BAD_CAFE, o);
    vectors++;
    if (o.rdata !== 32'h0BAD_CAFE || o.lat !== 3 || o.b_hs !== 0 || !o.after_ok) begin
      miscompares++;
      $display("FAIL rstmid_next_load: got rdata=%h lat=%0d b_hs=%0d after_ok=%b",
               o.rdata, o.lat, o.b_hs, o.after_ok);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    run_txn(1, 32'h8000_0102, 32'h0000_BEEF, 3'd1, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, o1);
    run_txn(0, 32'h8000_0102, 32'h0, 3'd5, 0, 0, 0, 0, 0, 0, 2'b00, 32'hBEEF_0000, o2);
    vectors++;
    if (o1.wdata !== 32'hBEEF_0000 || o1.wstrb !== 8'h0C || o1.lat !== 3) begin
      miscompares++;
      $display("FAIL b2b_store: got wdata=%h wstrb=%h lat=%0d want beef0000/0c/3",
               o1.wdata, o1.wstrb, o1.lat);
    end
    vectors++;
    if (o2.viol !== 0 || o2.lat !== 3 || o2.rdata !== 32'hBEEF_0000) begin
      miscompares++;
      $display("FAIL b2b_load: got viol=%0d lat=%0d rdata=%h want 0/3/beef0000",
               o2.viol, o2.lat, o2.rdata);
    end
  endtask

  task automatic test_random();
    obs_t o;
    for (int n = 0; n < 60; n++) begin
      bit          wen, mis;
      logic [2:0]  op;
      logic [31:0] addr, wdata, sdata;
      logic [1:0]  code;
      int          ar_lat, aw_lat, w_lat, b_lat, r_lat, rr_lat, idx;
      wen = 1'($urandom);
      idx = int'($urandom % 5);
      op  = wen ? 3'($urandom % 3) : 3'((idx < 3) ? idx : idx + 1);
      addr = $urandom; wdata = $urandom; sdata = $urandom;
      code = ($urandom % 4 == 0) ? 2'(1 + $urandom % 3) : 2'b00;
      ar_lat = int'($urandom % 4); aw_lat = int'($urandom % 4); w_lat = int'($urandom % 4);
      b_lat = int'($urandom % 4); r_lat = int'($urandom % 4); rr_lat = int'($urandom % 3);
      mis = model_mis(addr, op);
      run_txn(wen, addr, wdata, op, ar_lat, aw_lat, w_lat, b_lat, r_lat, rr_lat, code, sdata, o);
      vectors++;
      if (o.timeout || o.lat !== model_lat(wen, mis, ar_lat, aw_lat, w_lat, b_lat, r_lat)) begin
        miscompares++;
        $display("FAIL rnd%0d_lat: got %0d timeout=%b want %0d", n, o.lat, o.timeout,
                 model_lat(wen, mis, ar_lat, aw_lat, w_lat, b_lat, r_lat));
      end
      vectors++;
      if (o.err !== (mis || (code != 2'b00))) begin
        miscompares++;
        $display("FAIL rnd%0d_err: got %b want %b", n, o.err, mis || (code != 2'b00));
      end
      vectors++;
      if (o.rdata !== ((!wen && !mis) ? sdata : 32'd0)) begin
        miscompares++;
        $display("FAIL rnd%0d_rdata: got %h want %h", n, o.rdata,
                 (!wen && !mis) ? sdata : 32'd0);
      end
      vectors++;
      if (o.ar_hs !== int'(!wen && !mis) || o.r_hs !== int'(!wen && !mis) ||
          o.aw_hs !== int'(wen && !mis) || o.w_hs !== int'(wen && !mis) ||
          o.b_hs !== int'(wen && !mis)) begin
        miscompares++;
        $display("FAIL rnd%0d_handshakes: got ar=%0d r=%0d aw=%0d w=%0d b=%0d wen=%b mis=%b",
                 n, o.ar_hs, o.r_hs, o.aw_hs, o.w_hs, o.b_hs, wen, mis);
      end
      vectors++;
      if (o.viol !== 0 || o.unstable !== 0 || !o.after_ok || o.resp_cycles !== rr_lat + 1) begin
        miscompares++;
        $display("FAIL rnd%0d_protocol: got viol=%0d unstable=%0d after_ok=%b resp=%0d want 0/0/1/%0d",
                 n, o.viol, o.unstable, o.after_ok, o.resp_cycles, rr_lat + 1);
      end
      if (wen && !mis) begin
        vectors++;
        if (o.wdata !== model_wdata(wdata, addr) || o.wstrb !== model_wstrb(addr, op) ||
            o.awaddr !== addr) begin
          miscompares++;
          $display("FAIL rnd%0d_store: got wdata=%h wstrb=%h awaddr=%h want %h/%h/%h", n,
                   o.wdata, o.wstrb, o.awaddr, model_wdata(wdata, addr),
                   model_wstrb(addr, op), addr);
        end
      end
      if (!wen && !mis) begin
        vectors++;
        if (o.araddr !== addr) begin
          miscompares++; $display("FAIL rnd%0d_araddr: got %h want %h", n, o.araddr, addr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_stall();
    test_store_w_first();
    test_load_err_backpressure();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
